// File: rtl/timing_gen.sv
// timing_gen: 4004 two-phase clock, subcycle, sync, phase-flag and sc/dc generator
module timing_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic poc_n,
  input  logic two_word,
  output logic clk1,
  output logic clk2,
  output logic sync,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic sc,
  output logic dc
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  logic [DW-1:0] div, div_n;
  logic [1:0] slot, slot_n;
  logic [2:0] sub, sub_n;
  logic [7:0] ph;
  logic dw, sw, a1_start;
  always_comb begin
    dw = div == DMAX;
    sw = dw && slot == 2'd3;
    div_n = dw ? '0 : div + DW'(1);
    slot_n = dw ? slot + 2'd1 : slot;
    sub_n = sw ? sub + 3'd1 : sub;
    a1_start = sw && sub == 3'd7;
  end
  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      div <= DMAX;
      slot <= 2'd3;
      sub <= 3'd7;
      clk1 <= 1'b0;
      clk2 <= 1'b0;
      sync <= 1'b0;
      ph <= '0;
      dc <= 1'b0;
      sc <= 1'b1;
    end else begin
      div <= div_n;
      slot <= slot_n;
      sub <= sub_n;
      clk1 <= slot_n == 2'd0;
      clk2 <= slot_n == 2'd2;
      sync <= sub_n == 3'd7;
      if (dw && slot == 2'd1) ph <= 8'd1 << sub_n;
      if (a1_start) begin
        dc <= ~dc & two_word;
        sc <= ~(~dc & two_word);
      end
    end
  end
  assign {x32, x22, x12, m22, m12, a32, a22, a12} = ph;
endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: directed checks of timing_gen at CLK_DIV=2 and CLK_DIV=1
module tb_timing_gen;
  logic sysclk = 1'b0;
  logic poc_n = 1'b0;
  logic two_word = 1'b0;
  logic a_clk1, a_clk2, a_sync, a_sc, a_dc;
  logic b_clk1, b_clk2, b_sync, b_sc, b_dc;
  logic [7:0] a_ph, b_ph;
  logic [12:0] a_obs, b_obs;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [12:0] RST = 13'b000_00000000_1_0;
  always #5 sysclk = ~sysclk;
  assign a_obs = {a_clk1, a_clk2, a_sync, a_ph, a_sc, a_dc};
  assign b_obs = {b_clk1, b_clk2, b_sync, b_ph, b_sc, b_dc};
  timing_gen #(.CLK_DIV(2)) dut_a (
    .sysclk(sysclk), .poc_n(poc_n), .two_word(two_word),
    .clk1(a_clk1), .clk2(a_clk2), .sync(a_sync),
    .a12(a_ph[0]), .a22(a_ph[1]), .a32(a_ph[2]), .m12(a_ph[3]),
    .m22(a_ph[4]), .x12(a_ph[5]), .x22(a_ph[6]), .x32(a_ph[7]),
    .sc(a_sc), .dc(a_dc)
  );
  timing_gen #(.CLK_DIV(1)) dut_b (
    .sysclk(sysclk), .poc_n(poc_n), .two_word(two_word),
    .clk1(b_clk1), .clk2(b_clk2), .sync(b_sync),
    .a12(b_ph[0]), .a22(b_ph[1]), .a32(b_ph[2]), .m12(b_ph[3]),
    .m22(b_ph[4]), .x12(b_ph[5]), .x22(b_ph[6]), .x32(b_ph[7]),
    .sc(b_sc), .dc(b_dc)
  );
  function automatic logic [12:0] model(int i, int d, logic dcv);
    int p, s, q;
    logic [7:0] ph;
    p = (i - 1) % (32 * d);
    s = p / (4 * d);
    q = (p % (4 * d)) / d;
    ph = (i >= 1 + 2 * d) ? 8'd1 << (((i - 1 - 2 * d) / (4 * d)) % 8) : 8'd0;
    return {q == 0, q == 2, s == 7, ph, !dcv, dcv};
  endfunction
  task automatic step(int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask
  task automatic do_reset();
    poc_n = 1'b0;
    two_word = 1'b0;
    step(3);
    poc_n = 1'b1;
  endtask
  task automatic test_reset();
    poc_n = 1'b0;
    two_word = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      n_cmp++;
      if (a_obs !== RST) begin
        n_err++;
        $display("FAIL reset_a cycle %0d: got %b expected %b", i, a_obs, RST);
      end
    end
    n_cmp++;
    if (b_obs !== RST) begin
      n_err++;
      $display("FAIL reset_b: got %b expected %b", b_obs, RST);
    end
    poc_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (a_obs !== model(i, 2, 1'b0)) begin
        n_err++;
        $display("FAIL release cycle %0d: got %b expected %b", i, a_obs, model(i, 2, 1'b0));
      end
    end
  endtask
  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 192; i++) begin
      step(1);
      n_cmp++;
      if (a_obs !== model(i, 2, 1'b0)) begin
        n_err++;
        $display("FAIL free_run cycle %0d: got %b expected %b", i, a_obs, model(i, 2, 1'b0));
      end
      n_cmp++;
      if ((a_clk1 & a_clk2) !== 1'b0) begin
        n_err++;
        $display("FAIL overlap cycle %0d: got clk1&clk2=1 expected 0", i);
      end
    end
  endtask
  task automatic test_two_word();
    do_reset();
    step(1);
    two_word = 1'b1;
    for (int i = 2; i <= 256; i++) begin
      step(1);
      n_cmp++;
      if (a_obs !== model(i, 2, ((i - 1) / 64) % 2 == 1)) begin
        n_err++;
        $display("FAIL two_word cycle %0d: got %b expected %b", i, a_obs, model(i, 2, ((i - 1) / 64) % 2 == 1));
      end
    end
    two_word = 1'b0;
  endtask
  task automatic test_pulse();
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      two_word = (i >= 33 && i <= 40) || (i >= 125 && i <= 132);
      step(1);
      n_cmp++;
      if (a_obs !== model(i, 2, i >= 129 && i <= 192)) begin
        n_err++;
        $display("FAIL pulse cycle %0d: got %b expected %b", i, a_obs, model(i, 2, i >= 129 && i <= 192));
      end
    end
    two_word = 1'b0;
  endtask
  task automatic test_mid_reset();
    do_reset();
    two_word = 1'b1;
    step(1);
    two_word = 1'b0;
    step(45);
    n_cmp++;
    if (a_obs !== model(46, 2, 1'b1)) begin
      n_err++;
      $display("FAIL mid_x1_pre: got %b expected %b", a_obs, model(46, 2, 1'b1));
    end
    poc_n = 1'b0;
    step(1);
    n_cmp++;
    if (a_obs !== RST) begin
      n_err++;
      $display("FAIL mid_reset: got %b expected %b", a_obs, RST);
    end
    step(2);
    poc_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (a_obs !== model(i, 2, 1'b0)) begin
        n_err++;
        $display("FAIL restart cycle %0d: got %b expected %b", i, a_obs, model(i, 2, 1'b0));
      end
    end
  endtask
  task automatic test_clkdiv1();
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      step(1);
      n_cmp++;
      if (b_obs !== model(i, 1, 1'b0)) begin
        n_err++;
        $display("FAIL div1 cycle %0d: got %b expected %b", i, b_obs, model(i, 1, 1'b0));
      end
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_two_word();
    test_pulse();
    test_mid_reset();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
